mult_share_sched: RTL and testbench

- Time-shares one 17x8 signed fractional multiplier between NREQ butterfly lanes of the FFT datapath.
- Each lane submits an operand pair (17-bit sample, 8-bit Q1.7 twiddle component) over a valid/ready handshake.
- A round-robin scheduler issues one pair per cycle into a 2-stage pipeline.
- Each result returns with the tag of its originating lane, under downstream backpressure.

---
 rtl/fft_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/mult_share_sched.sv | 107 ++++++++++
 tb/tb_mult_share_sched.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared FFT datapath widths, saturation limits and operand types.
package fft_pkg;

  localparam int DATA_W = 17;
  localparam int COEF_W = 8;
  localparam int FRAC_W = 7;
  localparam int PROD_W = DATA_W + COEF_W;

  typedef logic signed [DATA_W-1:0] data_t;
  typedef logic signed [COEF_W-1:0] coef_t;

  localparam data_t DATA_MAX = 17'sh0FFFF;
  localparam data_t DATA_MIN = 17'sh10000;

  typedef struct packed {
    data_t a;
    coef_t b;
  } operand_t;

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter: first requester at or above ptr, wrapping.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int TAGW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic            en,
  input  logic [TAGW-1:0] ptr,
  output logic [NREQ-1:0] grant,
  output logic [TAGW-1:0] idx
);

  logic found;
  int   j;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = int'(ptr) + i;
      if (j >= NREQ) j = j - NREQ;
      if (en && !found && req[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        idx      = TAGW'(j);
      end
    end
  end

endmodule

// File: rtl/mult_share_sched.sv
// One 17x8 fractional multiplier time-shared across NREQ lanes.
// Build with MULT_SHARE_SAT_EN to saturate instead of wrap.
module mult_share_sched
  import fft_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int TAGW = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATA_W-1:0]   req_a,
  input  logic [NREQ*COEF_W-1:0]   req_b,
  output logic [NREQ-1:0]          req_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output data_t                    out_data,
  output logic [TAGW-1:0]          out_tag
);

  logic            s1_valid;
  operand_t        s1_op;
  logic [TAGW-1:0] s1_tag;
  logic [TAGW-1:0] ptr;

  logic            s2_adv;
  logic            s1_adv;
  logic            grant_any;
  logic [TAGW-1:0] grant_idx;
  operand_t        sel_op;

  logic signed [PROD_W-1:0] prod;
  data_t                    res;

  assign s2_adv    = !out_valid | out_ready;
  assign s1_adv    = !s1_valid | s2_adv;
  assign grant_any = |req_ready;

  rr_arbiter #(
    .NREQ (NREQ),
    .TAGW (TAGW)
  ) u_arb (
    .req   (req_valid),
    .en    (s1_adv & !rst),
    .ptr   (ptr),
    .grant (req_ready),
    .idx   (grant_idx)
  );

  always_comb begin
    sel_op = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        sel_op.a = req_a[i*DATA_W +: DATA_W];
        sel_op.b = req_b[i*COEF_W +: COEF_W];
      end
    end
  end

  // Floor-scale the Q1.7 product; only -65536 * -128 leaves range.
  always_comb begin
    prod = PROD_W'(s1_op.a) * PROD_W'(s1_op.b);
`ifdef MULT_SHARE_SAT_EN
    if ((prod >>> FRAC_W) > PROD_W'(DATA_MAX)) res = DATA_MAX;
    else if ((prod >>> FRAC_W) < PROD_W'(DATA_MIN)) res = DATA_MIN;
    else res = DATA_W'(prod >>> FRAC_W);
`else
    res = DATA_W'(prod >>> FRAC_W);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_tag   <= '0;
      ptr      <= '0;
    end else begin
      if (s1_adv) begin
        s1_valid <= grant_any;
        if (grant_any) begin
          s1_op  <= sel_op;
          s1_tag <= grant_idx;
        end
      end
      if (grant_any) begin
        if (grant_idx == TAGW'(NREQ - 1)) ptr <= '0;
        else ptr <= grant_idx + TAGW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_tag   <= '0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data <= res;
        out_tag  <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_mult_share_sched.sv
// Directed bench for mult_share_sched (MULT_SHARE_SAT_EN aware).
module tb_mult_share_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req_valid = '0;
  logic [67:0] req_a = '0;
  logic [31:0] req_b = '0;
  logic [3:0]  req_ready;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [16:0] out_data;
  logic [1:0]  out_tag;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  mult_share_sched #(
    .NREQ (4),
    .TAGW (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_lane(input int i, input logic [16:0] a,
                          input logic [7:0] b);
    req_a[i*17 +: 17] = a;
    req_b[i*8 +: 8]   = b;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req_valid = '0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic load_rr_lanes;
    for (int i = 0; i < 4; i++)
      set_lane(i, 17'(100 * (i + 1)), 8'd64);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    req_valid = 4'hF;
    tick();
    tick();
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_out_valid: got %b want 0", out_valid);
    end
    tests_run++;
    if (out_data !== 17'h0) begin
      tests_failed++;
      $display("FAIL reset_out_data: got %h want 0", out_data);
    end
    tests_run++;
    if (out_tag !== 2'd0) begin
      tests_failed++;
      $display("FAIL reset_out_tag: got %0d want 0", out_tag);
    end
    tests_run++;
    if (req_ready !== 4'b0000) begin
      tests_failed++;
      $display("FAIL reset_req_ready: got %b want 0000", req_ready);
    end
    req_valid = '0;
    rst = 1'b0;
  endtask

  task automatic test_single;
    int          lanes[3];
    logic [16:0] ta[3];
    logic [7:0]  tb[3];
    logic [16:0] te[3];
    logic [3:0]  mask;
    lanes = '{0, 2, 1};
    ta = '{17'd4360, 17'd256, 17'h1FF00};
    tb = '{8'd127, 8'd127, 8'd127};
    te = '{17'd4325, 17'd254, 17'h1FF02};
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_lane(lanes[k], ta[k], tb[k]);
      mask = 4'(1 << lanes[k]);
      req_valid = mask;
      #1;
      tests_run++;
      if (req_ready !== mask) begin
        tests_failed++;
        $display("FAIL single_grant%0d: got %b want %b", k, req_ready, mask);
      end
      tick();
      req_valid = '0;
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++;
        $display("FAIL single_early%0d: out_valid got %b want 0", k, out_valid);
      end
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== te[k] ||
          out_tag !== 2'(lanes[k])) begin
        tests_failed++;
        $display("FAIL single_result%0d: got v=%b d=%h t=%0d want v=1 d=%h t=%0d",
                 k, out_valid, out_data, out_tag, te[k], lanes[k]);
      end
    end
  endtask

  task automatic test_round_robin;
    logic [16:0] exp_d;
    do_reset();
    load_rr_lanes();
    req_valid = 4'hF;
    for (int c = 0; c < 10; c++) begin
      if (c == 8) req_valid = '0;
      #1;
      if (c < 8) begin
        tests_run++;
        if (req_ready !== 4'(1 << (c % 4))) begin
          tests_failed++;
          $display("FAIL rr_grant c%0d: got %b want %b",
                   c, req_ready, 4'(1 << (c % 4)));
        end
      end
      if (c >= 2) begin
        exp_d = 17'(50 * ((c - 2) % 4 + 1));
        tests_run++;
        if (out_valid !== 1'b1 || out_tag !== 2'((c - 2) % 4) ||
            out_data !== exp_d) begin
          tests_failed++;
          $display("FAIL rr_out c%0d: got v=%b t=%0d d=%0d want v=1 t=%0d d=%0d",
                   c, out_valid, out_tag, out_data, (c - 2) % 4, exp_d);
        end
      end
      tick();
    end
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL rr_drain: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_backpressure;
    do_reset();
    load_rr_lanes();
    req_valid = 4'hF;
    out_ready = 1'b0;
    #1;
    tests_run++;
    if (req_ready !== 4'b0001) begin
      tests_failed++;
      $display("FAIL bp_grant0: got %b want 0001", req_ready);
    end
    tick();
    tests_run++;
    if (req_ready !== 4'b0010 || out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_grant1: got r=%b v=%b want r=0010 v=0",
               req_ready, out_valid);
    end
    tick();
    for (int r = 0; r < 4; r++) begin
      tests_run++;
      if (req_ready !== 4'b0000 || out_valid !== 1'b1 ||
          out_tag !== 2'd0 || out_data !== 17'd50) begin
        tests_failed++;
        $display("FAIL bp_hold%0d: got r=%b v=%b t=%0d d=%0d want r=0000 v=1 t=0 d=50",
                 r, req_ready, out_valid, out_tag, out_data);
      end
      if (r < 3) tick();
    end
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== 4'b0100) begin
      tests_failed++;
      $display("FAIL bp_release_grant: got %b want 0100", req_ready);
    end
    tick();
    req_valid = '0;
    tests_run++;
    if (out_valid !== 1'b1 || out_tag !== 2'd1 || out_data !== 17'd100) begin
      tests_failed++;
      $display("FAIL bp_drain1: got v=%b t=%0d d=%0d want v=1 t=1 d=100",
               out_valid, out_tag, out_data);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_tag !== 2'd2 || out_data !== 17'd150) begin
      tests_failed++;
      $display("FAIL bp_drain2: got v=%b t=%0d d=%0d want v=1 t=2 d=150",
               out_valid, out_tag, out_data);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bp_empty: out_valid got %b want 0", out_valid);
    end
  endtask

  task automatic test_overflow;
    int          lanes[4];
    logic [16:0] ta[4];
    logic [7:0]  tb[4];
    logic [16:0] te[4];
    logic [3:0]  mask;
    lanes = '{0, 3, 1, 2};
    ta = '{17'h10000, 17'h0FFFF, 17'h1FFFF, 17'h0FFFF};
    tb = '{8'h80, 8'h80, 8'h01, 8'h7F};
`ifdef MULT_SHARE_SAT_EN
    te = '{17'h0FFFF, 17'h10001, 17'h1FFFF, 17'h0FDFF};
`else
    te = '{17'h10000, 17'h10001, 17'h1FFFF, 17'h0FDFF};
`endif
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      set_lane(lanes[k], ta[k], tb[k]);
      mask = 4'(1 << lanes[k]);
      req_valid = mask;
      #1;
      tests_run++;
      if (req_ready !== mask) begin
        tests_failed++;
        $display("FAIL ovf_grant%0d: got %b want %b", k, req_ready, mask);
      end
      tick();
      req_valid = '0;
      tick();
      tests_run++;
      if (out_valid !== 1'b1 || out_data !== te[k] ||
          out_tag !== 2'(lanes[k])) begin
        tests_failed++;
        $display("FAIL ovf_result%0d: got v=%b d=%h t=%0d want v=1 d=%h t=%0d",
                 k, out_valid, out_data, out_tag, te[k], lanes[k]);
      end
    end
  endtask

  task automatic test_mid_reset;
    req_valid = '0;
    out_ready = 1'b1;
    tick();
    load_rr_lanes();
    req_valid = 4'hF;
    out_ready = 1'b0;
    tick();
    tick();
    tests_run++;
    if (out_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL mrst_full: out_valid got %b want 1", out_valid);
    end
    rst = 1'b1;
    tick();
    tests_run++;
    if (out_valid !== 1'b0 || req_ready !== 4'b0000) begin
      tests_failed++;
      $display("FAIL mrst_clear: got v=%b r=%b want v=0 r=0000",
               out_valid, req_ready);
    end
    rst = 1'b0;
    req_valid = 4'b1010;
    out_ready = 1'b1;
    #1;
    tests_run++;
    if (req_ready !== 4'b0010) begin
      tests_failed++;
      $display("FAIL mrst_grant: got %b want 0010", req_ready);
    end
    tick();
    req_valid = '0;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mrst_no_stale: out_valid got %b want 0", out_valid);
    end
    tick();
    tests_run++;
    if (out_valid !== 1'b1 || out_tag !== 2'd1 || out_data !== 17'd100) begin
      tests_failed++;
      $display("FAIL mrst_result: got v=%b t=%0d d=%0d want v=1 t=1 d=100",
               out_valid, out_tag, out_data);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_overflow();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
